bitstreamer_mc: RTL and testbench

BITSTREAMER_MC -- requirements
Module: bitstreamer_mc

---
 rtl/bitstreamer_mc.sv | 188 ++++++++++++++++++
 tb/tb_bitstreamer_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstreamer_mc.sv
// Multi-channel bit-serial carrier modulator: sends a latched frame MSB-first and
// drives per-channel phase-shifted carriers into H-bridge gates with dead time.
module bitstreamer_mc #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned DATALEN  = 64,
  parameter int unsigned CNTLEN   = 8,
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned BIT_DIV  = 4,
  parameter int unsigned DEADTIME = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    repeat_en,
  input  logic [DATALEN-1:0]      datain,
  input  logic [CNTLEN-1:0]       nbits,
  input  logic [NCH*CNTLEN-1:0]   phase_delay,
  output logic                    busy,
  output logic                    done,
  output logic                    bitout,
  output logic [NCH-1:0]          car,
  output logic [NCH-1:0]          hi1,
  output logic [NCH-1:0]          lo1,
  output logic [NCH-1:0]          hi2,
  output logic [NCH-1:0]          lo2,
  output logic [NCH-1:0]          damp
);

  localparam int unsigned MW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned IW   = (DATALEN > 1) ? $clog2(DATALEN) : 1;
  localparam int unsigned DW   = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned NG   = 4 * NCH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_d;

  logic [MW-1:0]      mcnt;
  logic [BW-1:0]      bpcnt;
  logic [IW-1:0]      bidx;
  logic [DATALEN-1:0] data_sh;
  logic [IW-1:0]      last_sh;
  logic               rep_sh;
  logic [MW-1:0]      ph_sh [NCH];
  logic               stop_req;

  logic               launch;
  logic               finish;
  logic               mwrap;
  logic               period_end;
  logic               last_bit;
  logic               cur_bit;
  logic               run_bit;
  logic [NCH-1:0]     car_d;

  logic [NG-1:0]      raw_g;
  logic [NG-1:0]      gate_q;
  logic [DW-1:0]      dt_cnt [NG];

  // Carrier phase position of channel relative to the master counter, mod CLK_DIV.
  function automatic logic [MW-1:0] phase_off(input logic [MW-1:0] m, input logic [MW-1:0] p);
    logic [MW-1:0] r;
    if (m >= p) r = m - p;
    else        r = MW'(32'(m) + CLK_DIV - 32'(p));
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next state; a stop request or the final bit without repeat ends the frame at a bit boundary.
  always_comb begin
    state_d    = state;
    launch     = 1'b0;
    finish     = 1'b0;
    mwrap      = (mcnt == MW'(CLK_DIV - 1));
    period_end = (state == RUN) && mwrap && (bpcnt == BW'(BIT_DIV - 1));
    last_bit   = (bidx == last_sh);
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (period_end && (stop_req || stop || (last_bit && !rep_sh))) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow capture at launch and the mcnt / bit-period / bit-index counter chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt     <= '0;
      bpcnt    <= '0;
      bidx     <= '0;
      data_sh  <= '0;
      last_sh  <= '0;
      rep_sh   <= 1'b0;
      stop_req <= 1'b0;
      for (int k = 0; k < NCH; k++) ph_sh[k] <= '0;
    end else if (launch) begin
      mcnt     <= '0;
      bpcnt    <= '0;
      bidx     <= '0;
      data_sh  <= datain;
      rep_sh   <= repeat_en;
      stop_req <= 1'b0;
      if (nbits == '0 || 32'(nbits) > DATALEN) last_sh <= IW'(DATALEN - 1);
      else                                      last_sh <= IW'(nbits - CNTLEN'(1));
      for (int k = 0; k < NCH; k++) begin
        if (32'(phase_delay[k*CNTLEN +: CNTLEN]) >= CLK_DIV) ph_sh[k] <= MW'(CLK_DIV - 1);
        else ph_sh[k] <= MW'(phase_delay[k*CNTLEN +: CNTLEN]);
      end
    end else if (state == RUN) begin
      mcnt     <= mwrap ? '0 : mcnt + MW'(1);
      stop_req <= (stop_req || stop) && !finish;
      if (mwrap) bpcnt <= (bpcnt == BW'(BIT_DIV - 1)) ? '0 : bpcnt + BW'(1);
      if (period_end) bidx <= last_bit ? '0 : bidx + IW'(1);
    end
  end

  assign cur_bit = data_sh[IW'(DATALEN - 1) - bidx];
  assign run_bit = (state == RUN) && cur_bit;

  always_comb begin
    car_d = '0;
    for (int k = 0; k < NCH; k++)
      car_d[k] = run_bit && (phase_off(mcnt, ph_sh[k]) < MW'(HALF));
  end

  // Status and carrier outputs; damp is held inside the busy window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      bitout <= 1'b0;
      car    <= '0;
      damp   <= '0;
    end else begin
      busy   <= (state_d == RUN);
      done   <= finish;
      bitout <= run_bit;
      car    <= car_d;
      damp   <= {NCH{(state_d == RUN) && (state == RUN) && !cur_bit}};
    end
  end

  // Raw bridge drives ordered {lo2, hi2, lo1, hi1}; bitout doubles as bridge enable.
  assign raw_g = {car & {NCH{bitout}},
                  ~car & {NCH{bitout}},
                  ~car & {NCH{bitout}},
                  car & {NCH{bitout}}};

  // Dead-time: a gate rises once its raw drive has been high DEADTIME clocks, drops at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate_q <= '0;
      for (int g = 0; g < NG; g++) dt_cnt[g] <= '0;
    end else begin
      for (int g = 0; g < NG; g++) begin
        if (raw_g[g]) begin
          if (32'(dt_cnt[g]) < DEADTIME) dt_cnt[g] <= dt_cnt[g] + DW'(1);
          gate_q[g] <= (32'(dt_cnt[g]) + 32'd1 >= DEADTIME);
        end else begin
          dt_cnt[g] <= '0;
          gate_q[g] <= 1'b0;
        end
      end
    end
  end

  assign hi1 = gate_q[NCH-1:0];
  assign lo1 = gate_q[2*NCH-1:NCH];
  assign hi2 = gate_q[3*NCH-1:2*NCH];
  assign lo2 = gate_q[4*NCH-1:3*NCH];

endmodule

// File: tb/tb_bitstreamer_mc.sv
// Bench for bitstreamer_mc: every output is compared each cycle against a
// time-indexed model of the frame (bit k occupies clocks [16k,16k+16) after launch).
module tb_bitstreamer_mc;

  localparam int NCH  = 2;
  localparam int DL   = 8;
  localparam int CL   = 8;
  localparam int CD   = 8;
  localparam int BD   = 2;
  localparam int DT   = 1;
  localparam int BITP = CD * BD;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          repeat_en;
  logic [DL-1:0] datain;
  logic [CL-1:0] nbits;
  logic [NCH*CL-1:0] phase_delay;
  logic          busy;
  logic          done;
  logic          bitout;
  logic [NCH-1:0] car, hi1, lo1, hi2, lo2, damp;
  logic [14:0]   obs;

  int checks;
  int failures;

  int           m_nb;
  int           m_end;
  int           m_ph [2];
  logic [DL-1:0] m_data;

  bitstreamer_mc #(
    .NCH(NCH), .DATALEN(DL), .CNTLEN(CL), .CLK_DIV(CD), .BIT_DIV(BD), .DEADTIME(DT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .repeat_en(repeat_en),
    .datain(datain), .nbits(nbits), .phase_delay(phase_delay),
    .busy(busy), .done(done), .bitout(bitout), .car(car),
    .hi1(hi1), .lo1(lo1), .hi2(hi2), .lo2(lo2), .damp(damp)
  );

  assign obs = {busy, done, bitout, car, damp, hi1, lo1, hi2, lo2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame bit being transmitted t clocks after the launch edge (0 when not running).
  function automatic logic m_bit(input int t);
    if (t < 0 || t >= m_end) return 1'b0;
    return m_data[DL - 1 - ((t / BITP) % m_nb)];
  endfunction

  function automatic logic m_car(input int j, input int k);
    if (!m_bit(j - 1)) return 1'b0;
    return ((((j - 1 - m_ph[k]) % CD) + CD) % CD) < (CD / 2);
  endfunction

  // Raw drives {hi1, lo1, hi2, lo2} of channel k at sample j.
  function automatic logic [3:0] m_raw(input int j, input int k);
    logic c, en;
    c  = m_car(j, k);
    en = m_bit(j - 1);
    return {c, en & ~c, en & ~c, c};
  endfunction

  function automatic logic [14:0] m_out(input int j);
    logic bsy, dn, bo;
    logic [1:0] c, dp, h1, l1, h2, l2;
    logic [3:0] g;
    bsy = (j >= 0) && (j < m_end);
    dn  = (j == m_end);
    bo  = m_bit(j - 1);
    for (int k = 0; k < NCH; k++) begin
      c[k]  = m_car(j, k);
      dp[k] = bsy && (j >= 1) && !bo;
      g = 4'b1111;
      for (int i = 1; i <= DT; i++) g = g & m_raw(j - i, k);
      {h1[k], l1[k], h2[k], l2[k]} = g;
    end
    return {bsy, dn, bo, c, dp, h1, l1, h2, l2};
  endfunction

  // Latch the scenario into the model, then raise start; returns at sample j=0.
  task automatic do_launch(input logic [DL-1:0] d, input int nbv, input int p0, input int p1,
                           input logic rep, input int stop_j);
    int s_end;
    m_data  = d;
    m_nb    = (nbv == 0 || nbv > DL) ? DL : nbv;
    m_ph[0] = (p0 >= CD) ? CD - 1 : p0;
    m_ph[1] = (p1 >= CD) ? CD - 1 : p1;
    if (stop_j < 0) begin
      m_end = m_nb * BITP;
    end else begin
      s_end = ((stop_j + BITP) / BITP) * BITP;
      m_end = (rep || s_end < m_nb * BITP) ? s_end : m_nb * BITP;
    end
    datain      = d;
    nbits       = 8'(nbv);
    phase_delay = {8'(p1), 8'(p0)};
    repeat_en   = rep;
    start       = 1'b1;
    @(negedge clk);
  endtask

  task automatic scramble(input int j);
    datain      = 8'($urandom);
    nbits       = 8'($urandom);
    phase_delay = 16'($urandom);
    repeat_en   = 1'($urandom);
    start       = (j < m_end - 1) ? 1'($urandom) : 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    datain = '0; nbits = '0; phase_delay = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 15'd0) begin failures++; $display("FAIL reset_held got=%b exp=%b", obs, 15'd0); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 15'd0) begin failures++; $display("FAIL reset_idle got=%b exp=%b", obs, 15'd0); end
  endtask

  task automatic test_basic;
    do_launch(8'b1010_0000, 3, 0, 4, 1'b0, -1);
    for (int j = 0; j <= m_end + DT + 2; j++) begin
      checks++;
      if (obs !== m_out(j)) begin failures++; $display("FAIL basic j=%0d got=%b exp=%b", j, obs, m_out(j)); end
      checks++;
      if (((hi1 & lo1) | (hi2 & lo2)) !== 2'b00) begin
        failures++; $display("FAIL basic_overlap j=%0d hi1=%b lo1=%b hi2=%b lo2=%b", j, hi1, lo1, hi2, lo2);
      end
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_clamp_nbits0;
    do_launch(8'b1101_0110, 0, 3, 200, 1'b0, -1);
    for (int j = 0; j <= m_end + DT + 2; j++) begin
      checks++;
      if (obs !== m_out(j)) begin failures++; $display("FAIL clamp_nb0 j=%0d got=%b exp=%b", j, obs, m_out(j)); end
      scramble(j);
      @(negedge clk);
    end
  endtask

  task automatic test_repeat_stop;
    int sj;
    sj = 5 * BITP + 6;
    do_launch(8'b1100_0000, 2, 0, 4, 1'b1, sj);
    for (int j = 0; j <= m_end + DT + 2; j++) begin
      checks++;
      if (obs !== m_out(j)) begin failures++; $display("FAIL repeat_stop j=%0d got=%b exp=%b", j, obs, m_out(j)); end
      start = 1'b0;
      if (j == sj) stop = 1'b1;
      if (j == m_end) stop = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    do_launch(8'b1000_0000, 2, 2, 5, 1'b0, -1);
    for (int j = 0; j <= m_end; j++) begin
      checks++;
      if (obs !== m_out(j)) begin failures++; $display("FAIL b2b_first j=%0d got=%b exp=%b", j, obs, m_out(j)); end
      if (j < m_end) @(negedge clk);
    end
    do_launch(8'b0110_0000, 3, 6, 1, 1'b0, -1);
    for (int j = 0; j <= m_end + DT + 2; j++) begin
      checks++;
      if (obs !== m_out(j)) begin failures++; $display("FAIL b2b_second j=%0d got=%b exp=%b", j, obs, m_out(j)); end
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [DL-1:0] d;
    int nbv, p0, p1, sj, nbe;
    logic rep;
    for (int f = 0; f < 6; f++) begin
      d   = 8'($urandom);
      nbv = $urandom_range(0, 12);
      p0  = $urandom_range(0, 255);
      p1  = $urandom_range(0, 255);
      rep = 1'($urandom);
      nbe = (nbv == 0 || nbv > DL) ? DL : nbv;
      if (rep || $urandom_range(0, 1) == 1) sj = $urandom_range(0, nbe * BITP - 1);
      else sj = -1;
      do_launch(d, nbv, p0, p1, rep, sj);
      for (int j = 0; j <= m_end + DT + 2; j++) begin
        checks++;
        if (obs !== m_out(j)) begin
          failures++; $display("FAIL random f=%0d j=%0d got=%b exp=%b", f, j, obs, m_out(j));
        end
        scramble(j);
        if (j == sj) stop = 1'b1;
        if (j == m_end) stop = 1'b0;
        @(negedge clk);
      end
      start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (obs !== 15'd0) begin failures++; $display("FAIL random_idle f=%0d got=%b exp=%b", f, obs, 15'd0); end
    end
  endtask

  task automatic test_reset_midframe;
    do_launch(8'b1010_0000, 3, 0, 4, 1'b0, -1);
    for (int j = 0; j <= 20; j++) begin
      checks++;
      if (obs !== m_out(j)) begin failures++; $display("FAIL midrst_pre j=%0d got=%b exp=%b", j, obs, m_out(j)); end
      start = 1'b0;
      if (j < 20) @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 15'd0) begin failures++; $display("FAIL midrst_async got=%b exp=%b", obs, 15'd0); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (obs !== 15'd0) begin failures++; $display("FAIL midrst_held j=%0d got=%b exp=%b", j, obs, 15'd0); end
    end
    rst = 1'b1;
    do_launch(8'b1010_0000, 3, 0, 4, 1'b0, -1);
    for (int j = 0; j <= m_end + DT + 2; j++) begin
      checks++;
      if (obs !== m_out(j)) begin failures++; $display("FAIL midrst_post j=%0d got=%b exp=%b", j, obs, m_out(j)); end
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_clamp_nbits0;
    test_repeat_stop;
    test_back_to_back;
    test_random;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
